// File: rtl/fpu_bus_if.sv
// Byte-wide CPU register front-end for the combinational fpu.
// Holds operands and opcode for SETTLE_CYCLES, then captures the result and derives status flags.
package pa_fpu;
   typedef enum logic [1:0] {
      op_add = 2'd0,
      op_sub = 2'd1,
      op_mul = 2'd2,
      op_div = 2'd3
   } e_fpu_op;
endpackage

module fpu_bus_if #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic            rd_en,
   input  logic [3:0]      addr,
   input  logic [7:0]      wdata,
   output logic [7:0]      rdata,
   output logic            irq,
   output logic [31:0]     fpu_a,
   output logic [31:0]     fpu_b,
   output pa_fpu::e_fpu_op fpu_op,
   input  logic [31:0]     fpu_result
);

   typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_e;

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

   state_e          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [31:0]     a_q, a_d, b_q, b_d, res_q, res_d;
   pa_fpu::e_fpu_op op_q, op_d;
   logic            irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
   logic            nan_q, nan_d, inf_q, inf_d, zero_q, zero_d, sign_q, sign_d;
   logic [7:0]      rdata_q, rdata_d, rd_mux;
   logic            busy, settle_end;
   logic            wr_ab, wr_cmd, rd_ok, unused_wdata;
   logic [7:0]      res_exp;
   logic [22:0]     res_mant;

   assign wr_ab        = wr_en && !addr[3];
   assign wr_cmd       = wr_en && (addr == 4'd8);
   assign rd_ok        = rd_en && !wr_en;
   assign unused_wdata = ^wdata[6:2];
   assign res_exp      = fpu_result[30:23];
   assign res_mant     = fpu_result[22:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (wr_cmd) state_d = SETTLE;
         SETTLE:  if (cnt_q == 8'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q == SETTLE);
      settle_end = (state_q == SETTLE) && (cnt_q == 8'd0);
   end

   always_comb begin
      rd_mux = 8'h00;
      case (addr)
         4'd0, 4'd1, 4'd2, 4'd3:     rd_mux = a_q[{addr[1:0], 3'b000} +: 8];
         4'd4, 4'd5, 4'd6, 4'd7:     rd_mux = b_q[{addr[1:0], 3'b000} +: 8];
         4'd9:                       rd_mux = {1'b0, err_q, sign_q, zero_q, inf_q, nan_q, done_q, busy};
         4'd12, 4'd13, 4'd14, 4'd15: rd_mux = res_q[{addr[1:0], 3'b000} +: 8];
         default:                    rd_mux = 8'h00;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      op_d     = op_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      nan_d    = nan_q;
      inf_d    = inf_q;
      zero_d   = zero_q;
      sign_d   = sign_q;
      rdata_d  = rdata_q;

      if (wr_ab && !busy) begin
         if (!addr[2]) a_d[{addr[1:0], 3'b000} +: 8] = wdata;
         else          b_d[{addr[1:0], 3'b000} +: 8] = wdata;
      end
      if ((wr_ab || wr_cmd) && busy) err_d = 1'b1;
      if (wr_cmd && !busy) begin
         op_d     = pa_fpu::e_fpu_op'(wdata[1:0]);
         irq_en_d = wdata[7];
         done_d   = 1'b0;
         err_d    = 1'b0;
         cnt_d    = CNT_LOAD;
      end
      if (busy && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      if (rd_ok) begin
         rdata_d = rd_mux;
         if (addr == 4'd15) done_d = 1'b0;
      end
      // A capture on the same edge as a result-MSB read wins: the read saw the old result.
      if (settle_end) begin
         res_d  = fpu_result;
         nan_d  = (res_exp == 8'hFF) && (res_mant != 23'd0);
         inf_d  = (res_exp == 8'hFF) && (res_mant == 23'd0);
         zero_d = (res_exp == 8'h00) && (res_mant == 23'd0);
         sign_d = fpu_result[31];
         done_d = 1'b1;
      end
      irq_d = done_d & irq_en_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         op_q     <= pa_fpu::op_add;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         irq_q    <= 1'b0;
         cnt_q    <= '0;
         nan_q    <= 1'b0;
         inf_q    <= 1'b0;
         zero_q   <= 1'b0;
         sign_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         op_q     <= op_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
         irq_q    <= irq_d;
         cnt_q    <= cnt_d;
         nan_q    <= nan_d;
         inf_q    <= inf_d;
         zero_q   <= zero_d;
         sign_q   <= sign_d;
         rdata_q  <= rdata_d;
      end
   end

   assign rdata  = rdata_q;
   assign irq    = irq_q;
   assign fpu_a  = a_q;
   assign fpu_b  = b_q;
   assign fpu_op = op_q;

endmodule

// File: tb/tb_fpu_bus_if.sv
// Bench for fpu_bus_if: a stub fpu drives fpu_result from the block's outputs, and the bench
// predicts results, status bytes and irq timing from its own record of what it wrote.
module tb_fpu_bus_if;
   import pa_fpu::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, rd_en;
   logic [3:0]  addr;
   logic [7:0]  wdata, rdata;
   logic        irq;
   logic [31:0] fpu_a, fpu_b, fpu_result;
   e_fpu_op     fpu_op;

   int          total = 0;
   int          bad = 0;
   logic [31:0] last_res = 32'h0;

   always #5 clk = ~clk;

   fpu_bus_if #(.SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irq(irq), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
      .fpu_result(fpu_result)
   );

   // Stub fpu: exact IEEE answers for the directed cases, an op-dependent scramble otherwise.
   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
      if (op == 2'd0 && a == 32'h3f800000 && b == 32'h3f800000) return 32'h40000000;
      if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (op == 2'd2 && a == 32'h7f800000 && b == 32'h00000000) return 32'h7fc00000;
      if (op == 2'd0 && a == 32'h7f800000 && b == 32'h00000000) return 32'h7f800000;
      if (op == 2'd0 && a == 32'hbf800000 && b == 32'h3f800000) return 32'h00000000;
      return (a ^ {b[15:0], b[31:16]}) + {op, 28'h0, op};
   endfunction

   assign fpu_result = fpu_model(fpu_a, fpu_b, fpu_op);

   // Status flag bits (nan/inf/zero/sign) that a captured result should produce.
   function automatic logic [7:0] flag_bits(input logic [31:0] r);
      logic is_nan, is_inf, is_zero;
      is_nan  = (r[30:23] == 8'hFF) && (r[22:0] != 0);
      is_inf  = (r[30:23] == 8'hFF) && (r[22:0] == 0);
      is_zero = (r[30:23] == 8'h00) && (r[22:0] == 0);
      return {2'b00, r[31], is_zero, is_inf, is_nan, 2'b00};
   endfunction

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
      addr = a; rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      d = rdata;
   endtask

   task automatic write_ab(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 4; i++) bus_write(4'(i), a[i*8 +: 8]);
      for (int i = 0; i < 4; i++) bus_write(4'(4 + i), b[i*8 +: 8]);
   endtask

   task automatic read_result(output logic [31:0] r);
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         bus_read(4'(12 + i), d);
         r[i*8 +: 8] = d;
      end
   endtask

   task automatic wait_done(output logic [7:0] st);
      int n = 0;
      st = 8'h00;
      while (!st[1] && n < 20) begin
         bus_read(4'd9, st);
         n++;
      end
      if (!st[1]) begin
         total++; bad++;
         $display("FAIL wait_done: status=%h, done never set within 20 reads", st);
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
      total++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0) begin
         bad++; $display("FAIL reset_operands: got a=%h b=%h want 0", fpu_a, fpu_b); end
      total++; if (fpu_op !== op_add) begin bad++; $display("FAIL reset_op: got %0d want 0", fpu_op); end
      @(posedge clk); #1; rst_n = 1'b1;
      bus_read(4'd9, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", d); end
      bus_read(4'd15, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", d); end
      $display("reset: checked");
   endtask

   task automatic test_add();
      logic [7:0]  d;
      logic [31:0] r;
      write_ab(32'h3f800000, 32'h3f800000);
      bus_write(4'd8, 8'h00);
      for (int i = 0; i < 4; i++) begin
         bus_read(4'd9, d);
         total++; if (d !== 8'h01) begin bad++; $display("FAIL add_busy%0d: status %h want 01", i, d); end
      end
      bus_read(4'd9, d);
      total++; if (d !== 8'h02) begin bad++; $display("FAIL add_done: status %h want 02", d); end
      read_result(r);
      total++; if (r !== 32'h40000000) begin bad++; $display("FAIL add_result: got %h want 40000000", r); end
      bus_read(4'd9, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL add_done_clear: status %h want 00", d); end
      last_res = 32'h40000000;
      $display("add: 3f800000+3f800000 -> %h", r);
   endtask

   task automatic test_irq();
      logic [31:0] r;
      logic [7:0]  d;
      write_ab(32'h40000000, 32'h40400000);
      addr = 4'd8; wdata = 8'h82; wr_en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         total++; if (irq !== (k >= 5)) begin
            bad++; $display("FAIL irq_edge%0d: got %b want %b", k, irq, (k >= 5)); end
      end
      for (int i = 0; i < 3; i++) begin
         bus_read(4'(12 + i), d);
         r[i*8 +: 8] = d;
      end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b want 1", irq); end
      bus_read(4'd15, d);
      r[31:24] = d;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
      total++; if (r !== 32'h40C00000) begin bad++; $display("FAIL mul_result: got %h want 40C00000", r); end
      last_res = 32'h40C00000;
      $display("mul: 40000000*40400000 -> %h", r);
   endtask

   task automatic test_nan_inf();
      logic [7:0]  st;
      logic [31:0] r;
      write_ab(32'h7f800000, 32'h00000000);
      bus_write(4'd8, 8'h02);
      wait_done(st);
      total++; if (st !== 8'h06) begin bad++; $display("FAIL nan_status: got %h want 06", st); end
      read_result(r);
      total++; if (r !== 32'h7fc00000) begin bad++; $display("FAIL nan_result: got %h want 7fc00000", r); end
      bus_write(4'd8, 8'h00);
      wait_done(st);
      total++; if (st !== 8'h0A) begin bad++; $display("FAIL inf_status: got %h want 0a", st); end
      read_result(r);
      total++; if (r !== 32'h7f800000) begin bad++; $display("FAIL inf_result: got %h want 7f800000", r); end
      last_res = 32'h7f800000;
      $display("nan/inf: inf*0 then inf+0 -> %h", r);
   endtask

   task automatic test_busy_protect();
      logic [31:0] a0, b0, r, e1, e2;
      logic [7:0]  st;
      a0 = $urandom; b0 = $urandom;
      e1 = fpu_model(a0, b0, 2'd1);
      e2 = fpu_model(a0, b0, 2'd0);
      write_ab(a0, b0);
      bus_write(4'd8, 8'h01);
      bus_write(4'd0, 8'hFF);
      bus_write(4'd8, 8'h03);
      total++; if (fpu_a !== a0) begin bad++; $display("FAIL busy_a: got %h want %h", fpu_a, a0); end
      total++; if (fpu_op !== op_sub) begin bad++; $display("FAIL busy_op: got %0d want 1", fpu_op); end
      bus_read(4'd9, st);
      total++; if (st !== (8'h41 | flag_bits(last_res))) begin
         bad++; $display("FAIL busy_err: status %h want %h", st, 8'h41 | flag_bits(last_res)); end
      wait_done(st);
      total++; if (st !== (8'h42 | flag_bits(e1))) begin
         bad++; $display("FAIL busy_done: status %h want %h", st, 8'h42 | flag_bits(e1)); end
      read_result(r);
      total++; if (r !== e1) begin bad++; $display("FAIL busy_result: got %h want %h", r, e1); end
      bus_write(4'd8, 8'h00);
      bus_read(4'd9, st);
      total++; if (st !== (8'h01 | flag_bits(e1))) begin
         bad++; $display("FAIL err_clear: status %h want %h", st, 8'h01 | flag_bits(e1)); end
      wait_done(st);
      read_result(r);
      total++; if (r !== e2) begin bad++; $display("FAIL reuse_result: got %h want %h", r, e2); end
      last_res = e2;
      $display("busy: a=%h b=%h sub -> %h, add -> %h", a0, b0, e1, r);
   endtask

   task automatic test_zero_rw();
      logic [7:0] st, d;
      write_ab(32'hbf800000, 32'h3f800000);
      bus_write(4'd8, 8'h00);
      wait_done(st);
      total++; if (st !== 8'h12) begin bad++; $display("FAIL zero_status: got %h want 12", st); end
      addr = 4'd12; wdata = 8'hAA; wr_en = 1'b1; rd_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      total++; if (rdata !== 8'h12) begin bad++; $display("FAIL rw_hold: rdata %h want 12", rdata); end
      bus_read(4'd12, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL ro_result: got %h want 00", d); end
      bus_read(4'd9, d);
      total++; if (d !== 8'h12) begin bad++; $display("FAIL zero_done_kept: got %h want 12", d); end
      last_res = 32'h0;
      $display("zero: bf800000+3f800000 status %h", st);
   endtask

   task automatic test_random();
      logic [31:0] a, b, r, e;
      logic [1:0]  op;
      logic        ien;
      logic [7:0]  st, d;
      a = 32'h0; b = 32'h0;
      for (int i = 0; i < 16; i++) begin
         if (i == 0 || $urandom_range(0, 1) == 1) a = $urandom;
         if (i == 0 || $urandom_range(0, 1) == 1) b = $urandom;
         op  = 2'($urandom_range(0, 3));
         ien = 1'($urandom_range(0, 1));
         write_ab(a, b);
         bus_write(4'd8, {ien, 5'b0, op});
         e = fpu_model(a, b, op);
         wait_done(st);
         total++; if (st !== (8'h02 | flag_bits(e))) begin
            bad++; $display("FAIL rnd%0d_status: got %h want %h", i, st, 8'h02 | flag_bits(e)); end
         total++; if (irq !== ien) begin bad++; $display("FAIL rnd%0d_irq: got %b want %b", i, irq, ien); end
         read_result(r);
         total++; if (r !== e) begin bad++; $display("FAIL rnd%0d_result: got %h want %h", i, r, e); end
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL rnd%0d_irq_clr: got %b want 0", i, irq); end
         bus_read(4'd9, st);
         total++; if (st !== flag_bits(e)) begin
            bad++; $display("FAIL rnd%0d_flags: got %h want %h", i, st, flag_bits(e)); end
         case ($urandom_range(0, 2))
            0:       bus_read(4'd8, d);
            1:       bus_read(4'd10, d);
            default: bus_read(4'd11, d);
         endcase
         total++; if (d !== 8'h00) begin bad++; $display("FAIL rnd%0d_unmapped: got %h want 00", i, d); end
         last_res = e;
         $display("rnd %0d: a=%h b=%h op=%0d irq_en=%b -> %h", i, a, b, op, ien, r);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      write_ab($urandom | 32'h1, $urandom | 32'h1);
      bus_write(4'd8, 8'h81);
      bus_read(4'd9, d);
      total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL mid_busy: status %h want busy", d); end
      rst_n = 1'b0;
      #1;
      total++; if (rdata !== 8'h00 || irq !== 1'b0) begin
         bad++; $display("FAIL mid_rst_out: rdata=%h irq=%b want 00/0", rdata, irq); end
      total++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_op !== op_add) begin
         bad++; $display("FAIL mid_rst_fpu: a=%h b=%h op=%0d want 0", fpu_a, fpu_b, fpu_op); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus_read(4'd9, d);
         total++; if (d !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL mid_post%0d: status %h irq %b want 00/0", i, d, irq); end
      end
      $display("reset mid-operation: checked");
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 4'd0; wdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_irq();
      test_nan_inf();
      test_busy_protect();
      test_zero_rw();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
